// File: rtl/regbank_write_arbiter_if.sv
// Write-port sharing bus between the writeback requesters and the register bank arbiter.
// master = requester side, slave = arbiter side.
interface regbank_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 64
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      c;
    logic [DW-1:0]      cData;
    logic               write;
    logic               busy;

    modport master (
        output req, req_addr, req_data,
        input  gnt, c, cData, write, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, c, cData, write, busy
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port.
// The winner's address/data are latched at acceptance and write is held for
// WRITE_CYCLES clocks; gnt pulses during the final held cycle.
// Optional macro ZERO_REG_PROTECT_EN: requests targeting address 0 run the full
// transaction (c/cData, busy, gnt) but never raise write.
module regbank_write_arbiter #(
    parameter int NREQ         = 3,
    parameter int AW           = 5,
    parameter int DW           = 64,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regbank_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   c_q;
    logic [DW-1:0]   cdata_q;
    logic            write_q;
    logic            busy_q;
    logic [NREQ-1:0] gnt_q;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_next;
    logic [AW-1:0]   pick_addr;
    logic [DW-1:0]   pick_data;
    logic            pick_wr_en;
    int              scan_j;

    // Round-robin pick: first pending request at or after ptr, wrapping to 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_j = int'(ptr) + k;
            if (scan_j >= NREQ) begin
                scan_j = scan_j - NREQ;
            end
            if (!pick_found && bus.req[scan_j]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(scan_j);
            end
        end
        pick_addr = bus.req_addr[int'(pick_idx)*AW +: AW];
        pick_data = bus.req_data[int'(pick_idx)*DW +: DW];
        ptr_next  = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef ZERO_REG_PROTECT_EN
        pick_wr_en = (pick_addr != '0);
`else
        pick_wr_en = 1'b1;
`endif
    end

    // Transaction FSM with registered write-port drive and grant pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            winner  <= '0;
            cnt     <= '0;
            c_q     <= '0;
            cdata_q <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_q   <= '0;
                    write_q <= 1'b0;
                    if (pick_found) begin
                        winner  <= pick_idx;
                        c_q     <= pick_addr;
                        cdata_q <= pick_data;
                        write_q <= pick_wr_en;
                        busy_q  <= 1'b1;
                        cnt     <= CW'(WRITE_CYCLES - 1);
                        ptr     <= ptr_next;
                        state   <= WRITE;
                        // A single-cycle write is also its final cycle.
                        if (WRITE_CYCLES == 1) begin
                            gnt_q <= NREQ'(1) << pick_idx;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                        gnt_q   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            gnt_q <= NREQ'(1) << winner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.c     = c_q;
    assign bus.cData = cdata_q;
    assign bus.write = write_q;
    assign bus.busy  = busy_q;
endmodule
